fp32_mul_arbiter: RTL and testbench



---
 rtl/fp32_pkg.sv | 12 +
 rtl/fp32_mul_core.sv | 57 +++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/fp32_mul_arbiter.sv | 95 +++++++++
 tb/tb_fp32_mul_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 types for the multiply arbiter slice.
// Operand/product word type and fixed constants.
package fp32_pkg;

  localparam int FP32_W = 32;
  localparam int MAX_REQ = 16;

  typedef logic [FP32_W-1:0] fp32_t;

  localparam fp32_t QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp32_mul_core.sv
// Combinational FP32 multiply, round-to-nearest-even.
// Subnormal inputs/outputs are treated as zero.
module fp32_mul_core
  import fp32_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t p
);

  logic        sgn;
  logic        aZero, bZero, aInf, bInf, aNan, bNan;
  logic [47:0] mant;
  logic [22:0] frac;
  logic        guard, sticky, rnd;
  logic [23:0] fracR;
  int          expo;

  // normalise, round and classify the product
  always_comb begin
    sgn = a[31] ^ b[31];
    aZero = (a[30:23] == 8'h00);
    bZero = (b[30:23] == 8'h00);
    aInf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    bInf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    aNan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    bNan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    mant = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    expo = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (mant[47]) begin
      frac = mant[46:24];
      guard = mant[23];
      sticky = |mant[22:0];
      expo = expo + 1;
    end else begin
      frac = mant[45:23];
      guard = mant[22];
      sticky = |mant[21:0];
    end
    rnd = guard & (sticky | frac[0]);
    fracR = {1'b0, frac} + {23'b0, rnd};
    if (fracR[23]) expo = expo + 1;
    if (aNan || bNan || (aInf && bZero) || (aZero && bInf))
      p = QNAN;
    else if (aInf || bInf)
      p = {sgn, 8'hFF, 23'b0};
    else if (aZero || bZero)
      p = {sgn, 31'b0};
    else if (expo >= 255)
      p = {sgn, 8'hFF, 23'b0};
    else if (expo <= 0)
      p = {sgn, 31'b0};
    else
      p = {sgn, 8'(expo), fracR[22:0]};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index.
// Search starts at ptr and wraps from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int PW = $clog2(N);

  logic found;

  // first asserted request at or above ptr, with wrap
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fp32_mul_arbiter.sv
// Round-robin shared FP32 multiplier with a tagged
// fixed-latency pipeline and one-hot result valid.
module fp32_mul_arbiter
  import fp32_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*32-1:0]          req_a,
  input  logic [N_REQ*32-1:0]          req_b,
  input  logic                         flush,
  output logic [N_REQ-1:0]             rsp_valid,
  output fp32_t                        rsp_data,
  output logic                         busy,
  output logic [$clog2(LATENCY+1)-1:0] inflight
);

  localparam int PW = $clog2(N_REQ);

  typedef struct packed {
    logic             valid;
    logic [N_REQ-1:0] tag;
    fp32_t            product;
  } mul_stage_t;

  mul_stage_t       stg [1:LATENCY];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grantIdx;
  logic [PW-1:0]    nextPtr;
  logic [N_REQ-1:0] reqMasked;
  logic [N_REQ-1:0] grant;
  logic             xfer;
  logic             lastValid;
  fp32_t            opA, opB, prod;

  assign reqMasked = flush ? '0 : req_valid;

  rr_arbiter #(.N(N_REQ)) uArb (
    .req  (reqMasked),
    .ptr  (ptr),
    .grant(grant),
    .idx  (grantIdx)
  );

  assign req_ready = grant;
  assign xfer = |grant;
  assign opA = req_a[32*int'(grantIdx) +: 32];
  assign opB = req_b[32*int'(grantIdx) +: 32];
  assign nextPtr = (int'(grantIdx) == N_REQ-1) ? '0 : grantIdx + 1'b1;
  assign lastValid = stg[LATENCY].valid;

  fp32_mul_core uCore (
    .a(opA),
    .b(opB),
    .p(prod)
  );

  // pointer, pipeline stages and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      inflight <= '0;
      for (int i = 1; i <= LATENCY; i++) stg[i] <= '0;
    end else begin
      if (xfer) ptr <= nextPtr;
      stg[1].valid <= xfer;
      stg[1].tag <= grant;
      if (xfer) stg[1].product <= prod;
      for (int i = 2; i <= LATENCY; i++) begin
        stg[i].valid <= stg[i-1].valid;
        stg[i].tag <= stg[i-1].tag;
        // keep last live product so rsp_data holds when idle
        if (stg[i-1].valid && !flush)
          stg[i].product <= stg[i-1].product;
      end
      if (flush) begin
        inflight <= '0;
        for (int i = 1; i <= LATENCY; i++) stg[i].valid <= 1'b0;
      end else if (xfer && !lastValid) begin
        inflight <= inflight + 1'b1;
      end else if (!xfer && lastValid) begin
        inflight <= inflight - 1'b1;
      end
    end
  end

  assign rsp_valid = lastValid ? stg[LATENCY].tag : '0;
  assign rsp_data = stg[LATENCY].product;
  assign busy = (inflight != '0);

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Directed bench for fp32_mul_arbiter (N_REQ=4, LATENCY=2).
// Inputs change on negedge; outputs sampled 1ns later.
module tb_fp32_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   reqValid = '0;
  logic [127:0] reqA = '0;
  logic [127:0] reqB = '0;
  logic [3:0]   reqReady;
  logic [3:0]   rspValid;
  logic [31:0]  rspData;
  logic         busy;
  logic [1:0]   inflight;

  int checks = 0;
  int errors = 0;

  logic [31:0] opA [4] = '{32'h3F800000, 32'h40000000,
                           32'h40400000, 32'h40800000};
  logic [31:0] prodE [4] = '{32'h40000000, 32'h40800000,
                             32'h40C00000, 32'h41000000};

  always #5 clk = ~clk;

  fp32_mul_arbiter #(.N_REQ(4), .LATENCY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_a    (reqA),
    .req_b    (reqB),
    .flush    (flush),
    .rsp_valid(rspValid),
    .rsp_data (rspData),
    .busy     (busy),
    .inflight (inflight)
  );

  task automatic setLane(input int i, input logic [31:0] a,
                         input logic [31:0] b);
    reqA[32*i +: 32] = a;
    reqB[32*i +: 32] = b;
  endtask

  task automatic step(input logic [3:0] v, input logic f);
    @(negedge clk);
    reqValid = v;
    flush = f;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    reqValid = '0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL reset_rspValid: got %b want 0000", rspValid); end
    checks++; if (rspData !== 32'h0) begin errors++; $display("FAIL reset_rspData: got %h want 00000000", rspData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    checks++; if (reqReady !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", reqReady); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) setLane(i, opA[i], 32'h40000000);
    setLane(0, 32'h40000000, 32'h40400000);
    step(4'b0001, 1'b0);
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", reqReady); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL single_inf0: got %0d want 0", inflight); end
    step(4'b0000, 1'b0);
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL single_inf1: got %0d want 1", inflight); end
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL single_early: got %b want 0000", rspValid); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0001) begin errors++; $display("FAIL single_rspValid: got %b want 0001", rspValid); end
    checks++; if (rspData !== 32'h40C00000) begin errors++; $display("FAIL single_rspData: got %h want 40c00000", rspData); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL single_done: got %b want 0000", rspValid); end
    checks++; if (rspData !== 32'h40C00000) begin errors++; $display("FAIL single_hold: got %h want 40c00000", rspData); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL single_inf2: got %0d want 0", inflight); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
    setLane(0, opA[0], 32'h40000000);
  endtask

  task automatic test_round_robin();
    logic [3:0] expG, expR;
    logic [1:0] expI;
    doReset();
    for (int k = 0; k <= 10; k++) begin
      step(k < 8 ? 4'hF : 4'h0, 1'b0);
      expG = (k < 8) ? 4'(1 << (k % 4)) : 4'b0;
      expR = (k >= 2 && k <= 9) ? 4'(1 << ((k - 2) % 4)) : 4'b0;
      expI = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 :
             (k <= 8) ? 2'd2 : (k == 9) ? 2'd1 : 2'd0;
      checks++; if (reqReady !== expG) begin errors++; $display("FAIL rr_grant k=%0d: got %b want %b", k, reqReady, expG); end
      checks++; if (rspValid !== expR) begin errors++; $display("FAIL rr_rsp k=%0d: got %b want %b", k, rspValid, expR); end
      checks++; if (inflight !== expI) begin errors++; $display("FAIL rr_inflight k=%0d: got %0d want %0d", k, inflight, expI); end
      if (k >= 2 && k <= 9) begin
        checks++; if (rspData !== prodE[(k - 2) % 4]) begin errors++; $display("FAIL rr_data k=%0d: got %h want %h", k, rspData, prodE[(k - 2) % 4]); end
      end
    end
  endtask

  task automatic test_skip_idle();
    setLane(2, 32'h3FC00000, 32'hC0000000);
    step(4'b0100, 1'b0);
    checks++; if (reqReady !== 4'b0100) begin errors++; $display("FAIL skip_grant: got %b want 0100", reqReady); end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0100) begin errors++; $display("FAIL skip_rspValid: got %b want 0100", rspValid); end
    checks++; if (rspData !== 32'hC0400000) begin errors++; $display("FAIL skip_rspData: got %h want c0400000", rspData); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL skip_done: got %b want 0000", rspValid); end
    setLane(2, opA[2], 32'h40000000);
  endtask

  task automatic test_wrap();
    step(4'b1001, 1'b0);
    checks++; if (reqReady !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b want 1000", reqReady); end
    step(4'b0001, 1'b0);
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b want 0001", reqReady); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b1000) begin errors++; $display("FAIL wrap_rsp3: got %b want 1000", rspValid); end
    checks++; if (rspData !== 32'h41000000) begin errors++; $display("FAIL wrap_data3: got %h want 41000000", rspData); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0001) begin errors++; $display("FAIL wrap_rsp0: got %b want 0001", rspValid); end
    checks++; if (rspData !== 32'h40000000) begin errors++; $display("FAIL wrap_data0: got %h want 40000000", rspData); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL wrap_done: got %b want 0000", rspValid); end
  endtask

  task automatic test_flush();
    step(4'b0011, 1'b0);
    checks++; if (reqReady !== 4'b0010) begin errors++; $display("FAIL flush_g1: got %b want 0010", reqReady); end
    step(4'b0001, 1'b0);
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL flush_g0: got %b want 0001", reqReady); end
    step(4'b0001, 1'b1);
    checks++; if (reqReady !== 4'b0) begin errors++; $display("FAIL flush_noGrant: got %b want 0000", reqReady); end
    checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL flush_inf2: got %0d want 2", inflight); end
    checks++; if (rspValid !== 4'b0010) begin errors++; $display("FAIL flush_rspPre: got %b want 0010", rspValid); end
    step(4'b0001, 1'b0);
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL flush_rspKill: got %b want 0000", rspValid); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL flush_inf0: got %0d want 0", inflight); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL flush_regrant: got %b want 0001", reqReady); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL flush_rspKill2: got %b want 0000", rspValid); end
    checks++; if (rspData !== 32'h40800000) begin errors++; $display("FAIL flush_hold: got %h want 40800000", rspData); end
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL flush_inf1: got %0d want 1", inflight); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0001) begin errors++; $display("FAIL flush_after: got %b want 0001", rspValid); end
    checks++; if (rspData !== 32'h40000000) begin errors++; $display("FAIL flush_afterData: got %h want 40000000", rspData); end
    step(4'b0000, 1'b0);
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL flush_drain: got %0d want 0", inflight); end
  endtask

  task automatic test_reset_mid();
    step(4'b0001, 1'b0);
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL rmid_g0: got %b want 0001", reqReady); end
    step(4'b0010, 1'b0);
    checks++; if (reqReady !== 4'b0010) begin errors++; $display("FAIL rmid_g1: got %b want 0010", reqReady); end
    step(4'b0000, 1'b0);
    checks++; if (rspValid !== 4'b0001) begin errors++; $display("FAIL rmid_pre: got %b want 0001", rspValid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL rmid_rspValid: got %b want 0000", rspValid); end
    checks++; if (rspData !== 32'h0) begin errors++; $display("FAIL rmid_rspData: got %h want 00000000", rspData); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL rmid_inflight: got %0d want 0", inflight); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b0);
      checks++; if (rspValid !== 4'b0) begin errors++; $display("FAIL rmid_stale k=%0d: got %b want 0000", k, rspValid); end
      checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL rmid_inf k=%0d: got %0d want 0", k, inflight); end
    end
    step(4'b1111, 1'b0);
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: got %b want 0001", reqReady); end
    step(4'b0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_idle();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
